// File: rtl/cluster_eval_sched_pkg.sv
// rtl/cluster_eval_sched_pkg.sv - shared states, defaults and group-index width helper
package cluster_eval_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_IN_W  = 1894;
  localparam int DEF_OUT_W = 128;
  localparam int DEF_LANES = 8;

  // A single group still needs a one-bit index register.
  function automatic int grp_w(input int groups);
    return (groups > 1) ? $clog2(groups) : 1;
  endfunction

endpackage

// File: rtl/cluster_eval_sched_cone_bank.sv
// rtl/cluster_eval_sched_cone_bank.sv - combinational output-bit cones, LANES selected per group
module cluster_cone_bank
  import cluster_eval_sched_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LANES = DEF_LANES,
  parameter int G     = OUT_W / LANES,
  parameter int GW    = grp_w(G)
) (
  input  logic [IN_W-1:0]  vec,
  input  logic [GW-1:0]    g,
  output logic [LANES-1:0] lanes
);

  // Output bit b folds every input bit i with i mod OUT_W == b; odd bits are inverted.
  function automatic logic [IN_W-1:0] stride_mask();
    logic [IN_W-1:0] m;
    m = '0;
    for (int k = 0; k < (IN_W + OUT_W - 1) / OUT_W; k++) begin
      m = (m << OUT_W) | IN_W'(1);
    end
    return m;
  endfunction

  localparam logic [IN_W-1:0] STRIDE = stride_mask();

  logic [OUT_W-1:0] cone;
  logic [LANES-1:0] grp [G];

  for (genvar b = 0; b < OUT_W; b++) begin : g_cone
    assign cone[b] = (^(vec & (STRIDE << b))) ^ ((b % 2) == 1);
  end

  for (genvar gg = 0; gg < G; gg++) begin : g_grp
    assign grp[gg] = cone[gg*LANES +: LANES];
  end

  assign lanes = grp[g];

endmodule

// File: rtl/cluster_eval_sched.sv
// rtl/cluster_eval_sched.sv - request scheduler evaluating OUT_W bits LANES at a time
module cluster_eval_sched
  import cluster_eval_sched_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LANES = DEF_LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec,
  output logic             busy,
  output logic [31:0]      done_cnt
);

  localparam int SAFE_LANES = (LANES < 1) ? 1 : LANES;
  localparam int G  = OUT_W / SAFE_LANES;
  localparam int GW = grp_w(G);

  if (LANES < 1 || (OUT_W % SAFE_LANES) != 0) begin : g_bad_cfg
    $error("cluster_eval_sched: OUT_W must be a positive multiple of LANES");
  end

  state_t            state, state_nx;
  logic [IN_W-1:0]   vec_q;
  logic [GW-1:0]     g;
  logic [LANES-1:0]  lanes;
  logic [31:0]       cnt;

  cluster_cone_bank #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .LANES(LANES),
    .G    (G),
    .GW   (GW)
  ) u_bank (
    .vec  (vec_q),
    .g    (g),
    .lanes(lanes)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)             state_nx = ST_EVAL;
      ST_EVAL: if (g == GW'(G - 1))      state_nx = ST_DONE;
      ST_DONE: if (out_valid && out_ready) state_nx = ST_IDLE;
      default:                           state_nx = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign done_cnt = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      g         <= '0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            vec_q <= in_vec;
            g     <= '0;
          end
        end
        ST_EVAL: begin
          for (int gg = 0; gg < G; gg++) begin
            if (g == GW'(gg)) out_vec[gg*LANES +: LANES] <= lanes;
          end
          g <= g + 1'b1;
          if (g == GW'(G - 1)) out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_eval_sched.sv
// tb/tb_cluster_eval_sched.sv - randomized self-checking bench against a bit-fold reference model
module tb_cluster_eval_sched;

  localparam int IN_W  = 1894;
  localparam int OUT_W = 128;
  localparam int LANES = 8;
  localparam int LAT   = OUT_W / LANES;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;
  logic             busy;
  logic [31:0]      done_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  cluster_eval_sched #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .LANES(LANES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec  (out_vec),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit b: odd bits start at 1, then every set input bit i toggles bit i mod OUT_W.
  function automatic logic [OUT_W-1:0] golden(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    logic [IN_W-1:0]  vv;
    r = '0;
    for (int b = 0; b < OUT_W; b++) if (b % 2 == 1) r |= OUT_W'(1) << b;
    vv = v;
    for (int i = 0; i < IN_W; i++) begin
      if (vv[0]) r ^= OUT_W'(1) << (i % OUT_W);
      vv = vv >> 1;
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] v;
    v = '0;
    for (int k = 0; k < (IN_W + 31) / 32; k++) v = (v << 32) | IN_W'($urandom());
    return v;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Called at a negedge with in_ready high; returns at the negedge where out_valid is seen.
  task automatic send(input logic [IN_W-1:0] v, input bit hold, output int lat);
    in_valid = 1'b1;
    in_vec   = v;
    lat      = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
      if (out_valid) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_vec !== '0 || done_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b busy=%b done_cnt=%h out_vec=%h required 0/0/0/0",
               out_valid, busy, done_cnt, out_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_zero_vector();
    int lat;
    send('0, 1'b1, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL zero_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (out_vec !== golden('0)) begin
      errors++;
      $display("FAIL zero_result: got %h required %h", out_vec, golden('0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    checks++;
    if (done_cnt !== exp_cnt || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_handshake: done_cnt=%h in_ready=%b out_valid=%b required %h/1/0",
               done_cnt, in_ready, out_valid, exp_cnt);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [IN_W-1:0]  v;
    logic [OUT_W-1:0] exp;
    v = rand_vec();
    exp = golden(v);
    send(v, 1'b0, lat);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL stall_latency: got %0d required %0d", lat, LAT);
    end
    in_valid = 1'b1;
    in_vec   = rand_vec();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (out_vec !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: out_valid=%b in_ready=%b out_vec=%h required 1/0 %h",
                 c, out_valid, in_ready, out_vec, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    checks++;
    if (done_cnt !== exp_cnt || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: done_cnt=%h out_valid=%b in_ready=%b required %h/0/1",
               done_cnt, out_valid, in_ready, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [IN_W-1:0] v;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 32'd0;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      v = rand_vec();
      send(v, 1'b0, lat);
      checks++;
      if (lat != LAT || out_vec !== golden(v)) begin
        errors++;
        $display("FAIL b2b_result #%0d: lat=%0d out_vec=%h required lat=%0d %h",
                 n, lat, out_vec, LAT, golden(v));
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_at_handshake #%0d: got %b required 0", n, in_ready);
      end
      @(negedge clk);
      exp_cnt = sat_inc(exp_cnt);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_after #%0d: got %b required 1", n, in_ready);
      end
    end
    out_ready = 1'b0;
    checks++;
    if (done_cnt !== 32'd1000) begin
      errors++;
      $display("FAIL b2b_done_cnt: got %0d required 1000", done_cnt);
    end
  endtask

  task automatic test_reset_mid_eval();
    int lat;
    bit seen;
    logic [IN_W-1:0] v;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = rand_vec();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    checks++;
    if (out_vec !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_outputs: out_valid=%b busy=%b in_ready=%b done_cnt=%h out_vec=%h required 0/0/1/0/0",
               out_valid, busy, in_ready, done_cnt, out_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_stale_valid: got 1 required 0");
    end
    out_ready = 1'b1;
    v = rand_vec();
    send(v, 1'b0, lat);
    checks++;
    if (lat != LAT || out_vec !== golden(v)) begin
      errors++;
      $display("FAIL mid_reset_next: lat=%0d out_vec=%h required lat=%0d %h", lat, out_vec, LAT, golden(v));
    end
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
  endtask

  task automatic test_saturate();
    int lat;
    force dut.cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cnt;
    exp_cnt = 32'hFFFF_FFFE;
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      send(rand_vec(), 1'b0, lat);
      @(negedge clk);
      exp_cnt = sat_inc(exp_cnt);
      checks++;
      if (done_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL saturate #%0d: got %h required %h", n, done_cnt, exp_cnt);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_stall();
    test_back_to_back();
    test_reset_mid_eval();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cluster_eval_sched.md
CLUSTER_EVAL_SCHED -- requirements
Module: cluster_eval_sched

Interface
REQ-001 SHALL have parameter IN_W, default 1894, meaning width of the cluster input vector.
REQ-002 SHALL have parameter OUT_W, default 128, meaning number of output bits evaluated per request.
REQ-003 SHALL have parameter LANES, default 8, meaning output bits evaluated per cycle by the shared cone bank.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning a request is present on in_vec.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-008 SHALL have port in_vec, input, IN_W, meaning the request input vector.
REQ-009 SHALL have port out_valid, output, 1, meaning out_vec holds a complete result.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 SHALL have port out_vec, output, OUT_W, meaning the evaluated output bits, bit b = output bit b.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-013 SHALL have port done_cnt, output, 32, meaning the number of completed output handshakes, saturating.

Function
REQ-014 SHALL implement states IDLE, EVAL and DONE; G = OUT_W/LANES groups.
REQ-015 SHALL drive in_ready = 1 only in IDLE, combinationally from the state.
REQ-016 In IDLE, in_valid & in_ready SHALL latch in_vec into an internal register, clear the group counter to 0, and go to EVAL.
REQ-017 In EVAL, each cycle SHALL present the latched vector and the group index g to the cone bank, and write bank bits [LANES-1:0] into out_vec[g*LANES +: LANES] at the clock edge.
REQ-018 In EVAL, g SHALL increment by 1 per cycle; the edge that writes group G-1 SHALL move the state to DONE and set out_valid.
REQ-019 out_valid SHALL first be high exactly G cycles after the accepting edge (16 with defaults).
REQ-020 In DONE, out_vec and out_valid SHALL hold stable until out_valid & out_ready; that edge SHALL clear out_valid, move to IDLE and increment done_cnt.
REQ-021 in_ready SHALL be 0 in the cycle of the output handshake and SHALL be 1 in the next cycle; requests do not overlap.
REQ-022 in_valid in EVAL or DONE SHALL be ignored and SHALL not disturb the latched vector.
REQ-023 done_cnt SHALL saturate at 32'hFFFF_FFFF and SHALL not wrap.
REQ-024 Slices of out_vec not yet written in EVAL SHALL hold the previous request's values; only the value at out_valid is defined.
REQ-025 Elaboration SHALL fail if OUT_W mod LANES != 0 or LANES < 1.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, g = 0, out_valid = 0, busy = 0, out_vec = 0, done_cnt = 0 and latched vector = 0, including mid-EVAL or in DONE.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge, and no partial result from before reset SHALL ever be presented.

Structure
REQ-028 A shared package SHALL hold the state enumeration, default IN_W/OUT_W/LANES constants and the group-index width function clog2(G).
REQ-029 The shared cone bank SHALL be one combinational sub-module, cluster_cone_bank (inputs: vector, group index; output: LANES bits; each lane is one generated output-bit cone selected by g).
REQ-030 The scheduler SHALL contain no evaluation logic of its own beyond slice placement.

Verification
REQ-031 Reset release, then in_vec = all-zero with in_valid held 1 -> accept on the first edge, out_valid high 16 cycles later, out_vec equal to the golden-model result for the zero vector, done_cnt = 1 after out_ready.
REQ-032 out_ready held 0 for 50 cycles in DONE -> out_vec and out_valid stable for all 50 cycles, in_ready = 0, second in_valid ignored.
REQ-033 Back-to-back: 1000 random vectors with out_ready = 1 -> every result matches the golden model, in_ready high exactly 1 cycle after each handshake, done_cnt = 1000.
REQ-034 rst_n pulsed low at EVAL group 7 -> outputs zero immediately, no out_valid for that request, the next request evaluates correctly.
REQ-035 Force done_cnt to 32'hFFFF_FFFE, then complete 3 requests -> done_cnt = 32'hFFFF_FFFF.
REQ-036 LANES = 1, OUT_W = 4 build -> out_valid 4 cycles after accept; LANES = 3, OUT_W = 128 build -> elaboration error.
